// File: rtl/banner_pkg.sv
// banner_pkg: shared geometry constants and sequencer state encoding
package banner_pkg;
  localparam int ROWS   = 15;
  localparam int WORD_W = 70;
  localparam int WIN_W  = 16;
  localparam int ADDR_W = 5;
  localparam int OFF_W  = 7;
  typedef enum logic [2:0] {IDLE, ISSUE, FETCH, PRESENT, FRAME_END} state_t;
endpackage

// File: rtl/banner_window_sel.sv
// banner_window_sel: picks WIN_W columns starting at offset, wrapping past the last column
module banner_window_sel import banner_pkg::*; (
  input  logic [WORD_W-1:0] rom_data,
  input  logic [OFF_W-1:0]  offset,
  output logic [WIN_W-1:0]  row_data_next
);
  for (genvar i = 0; i < WIN_W; i++) begin : g_col
    logic [OFF_W-1:0] s, w, c;
    assign s = offset + OFF_W'(i);
    assign w = (s >= OFF_W'(WORD_W)) ? s - OFF_W'(WORD_W) : s;
    assign c = OFF_W'(WORD_W - 1) - w;
    assign row_data_next[WIN_W-1-i] = rom_data[c];
  end
endmodule

// File: rtl/banner_scroll_ctrl.sv
// banner_scroll_ctrl: walks the banner ROM row by row and streams scrolled windows to the row driver
module banner_scroll_ctrl import banner_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pause,
  input  logic              tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [WIN_W-1:0]  row_data,
  output logic [ADDR_W-1:0] row_idx,
  output logic              row_valid,
  input  logic              row_ready,
  output logic              frame_done,
  output logic [OFF_W-1:0]  offset,
  output logic              busy
);
  state_t state, nxt;
  logic [ADDR_W-1:0] row;
  logic [WIN_W-1:0] row_data_next;
  logic tick_pend;
  logic last_row;

  assign last_row = row == ADDR_W'(ROWS - 1);

  banner_window_sel u_win (
    .rom_data(rom_data),
    .offset(offset),
    .row_data_next(row_data_next)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  // next-state and frame status decode
  always_comb begin
    nxt = state;
    frame_done = state == FRAME_END;
    busy = state != IDLE;
    case (state)
      IDLE:      nxt = en ? ISSUE : IDLE;
      ISSUE:     nxt = FETCH;
      FETCH:     nxt = PRESENT;
      PRESENT:   nxt = row_ready ? (last_row ? FRAME_END : ISSUE) : PRESENT;
      FRAME_END: nxt = en ? ISSUE : IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // row walk, ROM address, presented row, tick latch and scroll offset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row <= '0;
      rom_addr <= '0;
      row_data <= '0;
      row_idx <= '0;
      row_valid <= 1'b0;
      offset <= '0;
      tick_pend <= 1'b0;
    end else begin
      tick_pend <= (state == FRAME_END) ? tick : (tick_pend | tick);
      case (state)
        IDLE:  row <= '0;
        ISSUE: rom_addr <= row;
        FETCH: begin
          row_data <= row_data_next;
          row_idx <= row;
          row_valid <= 1'b1;
        end
        PRESENT: if (row_ready) begin
          row_valid <= 1'b0;
          if (!last_row) row <= row + ADDR_W'(1);
        end
        FRAME_END: begin
          row <= '0;
          if (tick_pend && !pause)
            offset <= (offset == OFF_W'(WORD_W - 1)) ? '0 : offset + OFF_W'(1);
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// tb_banner_scroll_ctrl: randomized frame-level checks against a column-arithmetic model
module tb_banner_scroll_ctrl;
  logic clk = 0, rst_n = 0, en = 0, pause = 0, tick = 0, row_ready = 1;
  logic [4:0] rom_addr, row_idx;
  logic [69:0] rom_data;
  logic [15:0] row_data;
  logic row_valid, frame_done, busy;
  logic [6:0] offset;
  logic [69:0] rom [32];
  int checks = 0, errors = 0;
  int exp_off = 0;
  bit carry = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  banner_scroll_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pause(pause), .tick(tick),
    .rom_addr(rom_addr), .rom_data(rom_data), .row_data(row_data),
    .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready),
    .frame_done(frame_done), .offset(offset), .busy(busy)
  );

  // visible column i shows banner column (off+i) mod 70, leftmost banner column is bit 69
  function automatic logic [15:0] win(input logic [69:0] w, input int off);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = w[69 - ((off + i) % 70)];
    return r;
  endfunction

  // Runs one full frame from a negedge, checking every presented row and the frame timing.
  task automatic run_frame(input int nticks, input bit pz, input int stall_row, input int stall_len,
                           input bit rnd_ready, input int drop_en, input bit end_tick);
    int n, acc, first_v, st;
    int tk[3];
    bit pend, done;
    logic [15:0] hd;
    logic [4:0] hi;
    for (int i = 0; i < 3; i++) tk[i] = (i < nticks) ? int'($urandom_range(5, 40)) : -1;
    pend = carry || nticks > 0;
    en = 1;
    n = 0; acc = 0; first_v = -1; st = 0; done = 0; hd = '0; hi = '0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) pause = pz;
      tick = (n == tk[0] || n == tk[1] || n == tk[2]);
      if (n == drop_en) en = 0;
      if (row_valid && first_v < 0) first_v = n;
      if (row_valid) begin
        checks++;
        if (row_idx !== 5'(acc) || row_data !== win(rom[acc], exp_off) || offset !== 7'(exp_off)) begin
          errors++;
          $display("FAIL row: idx %0d data %h off %0d, expected idx %0d data %h off %0d",
                   row_idx, row_data, offset, acc, win(rom[acc], exp_off), exp_off);
        end
      end
      if (stall_len > 0 && acc == stall_row && st < stall_len && (row_valid || st > 0)) begin
        if (st == 0) begin
          hd = row_data; hi = row_idx;
        end else begin
          checks++;
          if (row_valid !== 1'b1 || row_data !== hd || row_idx !== hi || rom_addr !== 5'(stall_row)) begin
            errors++;
            $display("FAIL stall: valid %b data %h idx %0d addr %0d, expected 1 %h %0d %0d",
                     row_valid, row_data, row_idx, rom_addr, hd, hi, stall_row);
          end
        end
        row_ready = 0;
        st++;
      end else row_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (row_valid && row_ready) acc++;
      if (frame_done) begin
        done = 1;
        checks++;
        if (acc != 15) begin
          errors++;
          $display("FAIL frame_rows: accepted %0d, expected 15", acc);
        end
        if (!rnd_ready && stall_len == 0) begin
          checks++;
          if (first_v != 3 || n != 46) begin
            errors++;
            $display("FAIL frame_timing: first valid %0d done %0d, expected 3 and 46", first_v, n);
          end
        end
        tick = end_tick;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL frame_timeout: no frame_done within %0d cycles", n);
    end
    if (pend && !pz) exp_off = (exp_off + 1) % 70;
    carry = end_tick;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (rom_addr !== 0 || row_idx !== 0 || row_data !== 0 || row_valid !== 0 ||
        frame_done !== 0 || busy !== 0 || offset !== 0) begin
      errors++;
      $display("FAIL reset: addr %0d idx %0d data %h v %b fd %b busy %b off %0d, expected all zero",
               rom_addr, row_idx, row_data, row_valid, frame_done, busy, offset);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL idle_busy: busy %b, expected 0", busy);
    end
  endtask

  task automatic test_first_frame;
    run_frame(0, 0, -1, 0, 0, 0, 0);
  endtask

  task automatic test_tick;
    run_frame(1, 0, -1, 0, 0, 0, 0);
    run_frame(3, 0, -1, 0, 0, 0, 0);
    run_frame(0, 0, -1, 0, 0, 0, 1);
    run_frame(0, 0, -1, 0, 0, 0, 0);
    run_frame(0, 0, -1, 0, 0, 0, 0);
  endtask

  task automatic test_wrap;
    while (exp_off != 60) run_frame($urandom_range(1, 3), 0, -1, 0, 0, 0, 0);
    run_frame(0, 0, -1, 0, 0, 0, 0);
    while (exp_off != 69) run_frame(1, 0, -1, 0, 0, 0, 0);
    run_frame(2, 0, -1, 0, 0, 0, 0);
    run_frame(0, 0, -1, 0, 0, 0, 0);
  endtask

  task automatic test_backpressure;
    run_frame(0, 0, 7, 6, 0, 0, 0);
    run_frame(1, 0, -1, 0, 1, 0, 0);
    run_frame(0, 0, -1, 0, 1, 0, 0);
  endtask

  task automatic test_pause_en;
    for (int f = 0; f < 3; f++) run_frame(2, 1, -1, 0, 0, 0, 0);
    run_frame(1, 0, -1, 0, 0, 20, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 0 || row_valid !== 0 || frame_done !== 0) begin
        errors++;
        $display("FAIL stop_idle: busy %b valid %b fd %b, expected 0 0 0", busy, row_valid, frame_done);
      end
    end
  endtask

  task automatic test_async_reset;
    int n;
    run_frame(1, 0, -1, 0, 0, 0, 0);
    en = 1;
    n = 0;
    while (!(row_valid && row_idx == 5) && n < 200) begin
      @(negedge clk);
      n++;
      tick = (n == 4);
    end
    tick = 0;
    row_ready = 0;
    checks++;
    if (!(row_valid && row_idx == 5) || offset == 0) begin
      errors++;
      $display("FAIL reset_setup: valid %b idx %0d off %0d, expected row 5 presented with nonzero offset",
               row_valid, row_idx, offset);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (rom_addr !== 0 || row_idx !== 0 || row_data !== 0 || row_valid !== 0 ||
        frame_done !== 0 || busy !== 0 || offset !== 0) begin
      errors++;
      $display("FAIL async_reset: addr %0d idx %0d data %h v %b fd %b busy %b off %0d, expected all zero",
               rom_addr, row_idx, row_data, row_valid, frame_done, busy, offset);
    end
    en = 0;
    row_ready = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_off = 0;
    carry = 0;
    run_frame(0, 0, -1, 0, 0, 0, 0);
    run_frame(0, 0, -1, 0, 0, 0, 0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rom[r] = {6'($urandom), $urandom, $urandom};
    test_reset;
    test_first_frame;
    test_tick;
    test_wrap;
    test_backpressure;
    test_pause_en;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/banner_scroll_ctrl.md
Name: banner_scroll_ctrl

Overview:
- Sequencer for the 15-row x 70-bit banner word ROM.
- Walks the ROM address row by row and absorbs the ROM's one-cycle registered-address latency.
- Extracts a WIN_W-column window at a scroll offset and hands each row to the LED-matrix row driver over a valid/ready handshake.
- Advances the scroll offset once per frame when a scroll tick has arrived, wrapping modulo WORD_W.

Parameters:
- ROWS, 15: number of banner rows; ROM addresses 0..ROWS-1.
- WORD_W, 70: ROM word width (banner columns). Word bit WORD_W-1 is the leftmost column.
- WIN_W, 16: visible window width in columns, WIN_W <= WORD_W.
- ADDR_W, 5: ROM address width.
- OFF_W, 7: scroll offset width, with 2^OFF_W >= WORD_W.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: level. High = run frames continuously; low = stop at the next frame boundary.
- pause, input, 1: level. High = freeze the offset at frame end; frames keep running.
- tick, input, 1: single-cycle scroll-step pulse.
- rom_addr, output, ADDR_W: registered address to the ROM.
- rom_data, input, WORD_W: ROM output. Valid in the cycle after rom_addr has crossed one rising edge.
- row_data, output, WIN_W: window pixels. Bit WIN_W-1 is the leftmost visible column.
- row_idx, output, ADDR_W: row number of row_data.
- row_valid, output, 1: row_data and row_idx are valid.
- row_ready, input, 1: the sink accepts the row on a cycle where row_valid && row_ready.
- frame_done, output, 1: one-cycle pulse after the last row is accepted.
- offset, output, OFF_W: current scroll offset, range 0..WORD_W-1.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset is asynchronous and active-low, and immediate even mid-frame. Reset state:
  - state = IDLE
  - rom_addr = 0, row_idx = 0, row_data = 0
  - row_valid = 0, frame_done = 0, busy = 0
  - offset = 0, tick_pend = 0
- tick_pend: set on any cycle with tick = 1. Cleared in FRAME_END, except that a tick arriving in the FRAME_END cycle itself is retained and sets tick_pend for the next frame. Multiple ticks within one frame count as a single step.
- FSM states: IDLE, ISSUE, FETCH, PRESENT, FRAME_END.
  - IDLE: if en = 1, go to ISSUE with row = 0.
  - ISSUE: rom_addr <= row. Next state FETCH.
  - FETCH: rom_data is valid for rom_addr. At the end of this cycle:
    - row_data <= window(rom_data, offset)
    - row_idx <= row
    - row_valid <= 1
    - next state PRESENT
  - PRESENT: hold row_data, row_idx and row_valid stable until row_ready = 1. On acceptance:
    - row_valid <= 0
    - if row = ROWS-1, go to FRAME_END; otherwise row <= row+1 and go to ISSUE.
  - FRAME_END (one cycle):
    - frame_done = 1
    - if tick_pend && !pause: offset <= (offset == WORD_W-1) ? 0 : offset+1
    - if en, go to ISSUE with row = 0; otherwise go to IDLE.
- Latency: 2 cycles from entering ISSUE to row_valid = 1. With row_ready tied high, a frame takes ROWS*3+1 = 46 cycles.
- Window rule: row_data[WIN_W-1-i] = rom_data[WORD_W-1-((offset+i) mod WORD_W)] for i = 0..WIN_W-1.
  - Wrap-around is implemented with a conditional subtract (sum >= WORD_W -> sum - WORD_W). No divider.
- en falling mid-frame: the frame completes, then the FSM goes to IDLE. It never abandons a presented row.
- The offset changes only in FRAME_END, so every row of one frame uses the same offset.

Decomposition:
- Package banner_pkg holds:
  - the ROWS, WORD_W, WIN_W, ADDR_W and OFF_W constants
  - the state enum typedef {IDLE, ISSUE, FETCH, PRESENT, FRAME_END}
- One sub-module, banner_window_sel: combinational window extraction with wrap, driven by (rom_data, offset) and producing row_data_next.
- The FSM, counters and handshake logic live in banner_scroll_ctrl.

Test Plan:
1. Reset, then en = 1, row_ready = 1, offset 0 -> rows 0/3/12 give row_data = 16'hFC0F / 16'hE38E / 16'hE38F. First row_valid 2 cycles after ISSUE. frame_done pulses at cycle 46.
2. One tick pulse mid-frame 0, pause = 0 -> offset becomes 1 in FRAME_END. Frame 1 row 0 = 16'hF81F. Three ticks in one frame still advance offset by exactly 1.
3. Force offset to 60 via ticks (60 frames) -> row 0 = 16'h007F, exercising the wrap. Offset at 69 plus a tick -> 0.
4. row_ready low for 5 cycles on row 7 -> row_valid stays high, and row_data/row_idx stay stable and equal to 7's values. No address advance. Row 8 is issued only after the handshake.
5. pause = 1 with ticks every frame -> offset is frozen and frame_done still pulses. Drop en mid-frame -> the remaining rows are delivered, then IDLE and busy = 0.
6. Assert rst_n low during PRESENT of row 5 -> outputs go immediately to reset values. After release with en = 1, restart at row 0 with offset 0.
